exp_sequencer: RTL and testbench

- Multi-cycle sequencer for the iterative EXP functional unit in the EXE stage of the ARM pipeline.
- Accepts the EXP request from the control unit decode and drives the iterative datapath: one init pulse, then a fixed number of step enables.
- Freezes the pipeline and gates writeback until the result is ready.
- Supports a pause input (memory-side stall) and a branch flush that aborts the operation.

---
 rtl/exp_sequencer_pkg.sv | 20 ++
 rtl/exp_iter_counter.sv | 35 +++
 rtl/exp_sequencer.sv | 132 +++++++++++++
 tb/tb_exp_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_sequencer_pkg.sv
// Shared definitions for the EXP multi-cycle sequencer: FSM state encoding,
// the decoded opcode value and default sizing of the iteration counter.
package exp_sequencer_pkg;

  // Sequencer states; the encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } exp_state_e;

  // Opcode the control unit decodes into the start request.
  localparam logic [3:0] EXP_OPCODE = 4'b0011;

  // Default number of datapath steps and counter width (2^CNT_W > ITERATIONS-1).
  localparam int unsigned DEF_ITERATIONS = 20;
  localparam int unsigned DEF_CNT_W      = 5;

endpackage : exp_sequencer_pkg

// File: rtl/exp_iter_counter.sv
// Iteration counter for the EXP datapath: synchronous clear (priority over
// enable), enable-gated increment and a terminal-count flag for the last step.
module exp_iter_counter
  import exp_sequencer_pkg::*;
#(
  parameter int unsigned ITERATIONS = DEF_ITERATIONS,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(ITERATIONS - 1);

  logic [CNT_W-1:0] r_count;

  // Count register: clear wins over enable, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LP_LAST);

endmodule : exp_iter_counter

// File: rtl/exp_sequencer.sv
// Multi-cycle sequencer for the iterative EXP unit in EXE. Issues one init
// pulse then ITERATIONS step enables, freezes the pipeline while the result is
// pending and pulses done for exactly one cycle when writeback may proceed.
// A flush, or start dropping during INIT/RUN, aborts the operation silently.
//
// Handshake: start is a level request held by the pipeline while the EXP
// instruction is frozen in EXE; the sequencer acknowledges by dropping freeze
// (wb_ready=1) together with a one-cycle done pulse. The pipeline must keep
// start high until that cycle; any earlier drop is treated as a kill.
module exp_sequencer
  import exp_sequencer_pkg::*;
#(
  parameter int unsigned ITERATIONS = DEF_ITERATIONS,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic             flush,
  output logic             iter_init,
  output logic             iter_en,
  output logic [CNT_W-1:0] iter_idx,
  output logic             busy,
  output logic             freeze,
  output logic             wb_ready,
  output logic             done,
  output logic [1:0]       dbg_state
);

  exp_state_e       r_state;
  exp_state_e       w_next_state;
  logic             w_abort;
  logic             w_step;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_tc;
  logic [CNT_W-1:0] w_count;

  // Kill condition for an operation in INIT or RUN: flush or a dropped request.
  assign w_abort   = flush | ~start;
  // One datapath step happens in RUN whenever not stalled and not killed.
  assign w_step    = (r_state == ST_RUN) & ~hold & ~w_abort;
  // The counter only carries a value while stepping; everywhere else it returns to 0.
  assign w_cnt_clr = (r_state != ST_RUN) | w_abort;
  // The last step leaves the count on ITERATIONS-1 so DONE still reports it.
  assign w_cnt_en  = w_step & ~w_tc;

  exp_iter_counter #(
    .ITERATIONS (ITERATIONS),
    .CNT_W      (CNT_W)
  ) u_iter_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // State register with asynchronous active-low reset to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush) begin
          w_next_state = ST_INIT;
        end
      end
      ST_INIT: begin
        w_next_state = w_abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (w_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_step && w_tc) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode; freeze is gated by reset so it is low while rst is asserted.
  always_comb begin
    iter_init = 1'b0;
    iter_en   = 1'b0;
    iter_idx  = w_count;
    busy      = 1'b0;
    freeze    = 1'b0;
    done      = 1'b0;
    dbg_state = r_state;
    case (r_state)
      ST_IDLE: begin
        freeze = rst & start & ~flush;
      end
      ST_INIT: begin
        busy      = 1'b1;
        iter_init = ~w_abort;
        freeze    = ~w_abort;
      end
      ST_RUN: begin
        busy    = 1'b1;
        iter_en = w_step;
        freeze  = ~w_abort;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = ~flush;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    wb_ready = ~freeze;
  end

endmodule : exp_sequencer

// File: tb/tb_exp_sequencer.sv
// Self-checking bench for exp_sequencer. Each scenario fills per-cycle
// stimulus tables, a schedule-level reference model turns them into expected
// per-cycle output vectors (exp_q), the driver records what the DUT shows and
// the scenario task compares them, plus a few hand-derived spot checks.
module tb_exp_sequencer;

  localparam int ITER = 20;
  localparam int CW   = 5;
  localparam int MAXC = 256;

  logic          clk;
  logic          rst;
  logic          start;
  logic          hold;
  logic          flush;
  logic          iter_init;
  logic          iter_en;
  logic [CW-1:0] iter_idx;
  logic          busy;
  logic          freeze;
  logic          wb_ready;
  logic          done;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  bit          start_a[MAXC];
  bit          hold_a[MAXC];
  bit          flush_a[MAXC];
  logic [10:0] obs_a[MAXC];
  logic [10:0] exp_q[$];

  exp_sequencer #(
    .ITERATIONS (ITER),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .flush     (flush),
    .iter_init (iter_init),
    .iter_en   (iter_en),
    .iter_idx  (iter_idx),
    .busy      (busy),
    .freeze    (freeze),
    .wb_ready  (wb_ready),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {init, en, idx[4:0], busy, freeze, wb_ready, done}
  function automatic logic [10:0] pk(input bit i_init, input bit i_en, input int i_idx,
                                     input bit i_busy, input bit i_frz, input bit i_wb,
                                     input bit i_done);
    logic [4:0] idx5;
    idx5 = 5'(i_idx);
    return {i_init, i_en, idx5, i_busy, i_frz, i_wb, i_done};
  endfunction

  // ---------------- driver ----------------
  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      start_a[i] = 1'b0;
      hold_a[i]  = 1'b0;
      flush_a[i] = 1'b0;
      obs_a[i]   = '0;
    end
  endtask

  // Called at a falling edge; applies one table row per cycle and samples 1ns later.
  task automatic drive(input int n);
    for (int c = 0; c < n; c++) begin
      start = start_a[c];
      hold  = hold_a[c];
      flush = flush_a[c];
      #1;
      obs_a[c] = {iter_init, iter_en, iter_idx, busy, freeze, wb_ready, done};
      @(negedge clk);
    end
  endtask

  // ---------------- reference model ----------------
  // Works per operation: find the accept cycle, the init cycle, then count
  // ITER non-held cycles as steps, then one result cycle. Any kill ends the
  // operation in the cycle it is seen. Pushes one expected vector per cycle.
  task automatic model_run(input int n);
    int c;
    int steps;
    bit killed;
    c = 0;
    while (c < n) begin
      if (!(start_a[c] && !flush_a[c])) begin
        exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0));
        c++;
        continue;
      end
      exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0));
      c++;
      if (c >= n) break;
      if (flush_a[c] || !start_a[c]) begin
        exp_q.push_back(pk(0, 0, 0, 1, 0, 1, 0));
        c++;
        continue;
      end
      exp_q.push_back(pk(1, 0, 0, 1, 1, 0, 0));
      c++;
      steps  = 0;
      killed = 1'b0;
      while (steps < ITER && c < n) begin
        if (flush_a[c] || !start_a[c]) begin
          exp_q.push_back(pk(0, 0, steps, 1, 0, 1, 0));
          killed = 1'b1;
          c++;
          break;
        end
        exp_q.push_back(pk(0, !hold_a[c], steps, 1, 1, 0, 0));
        if (!hold_a[c]) steps++;
        c++;
      end
      if (killed || c >= n) continue;
      exp_q.push_back(pk(0, 0, ITER - 1, 1, 0, 1, !flush_a[c]));
      c++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [10:0] e;
    rst = 1'b0; start = 1'b0; hold = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    e = pk(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if ({iter_init, iter_en, iter_idx, busy, freeze, wb_ready, done} !== e) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h",
               {iter_init, iter_en, iter_idx, busy, freeze, wb_ready, done}, e);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_stim();
    drive(10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
  endtask

  task automatic test_single_run();
    logic [10:0] e;
    clear_stim();
    for (int c = 0; c <= 22; c++) start_a[c] = 1'b1;
    model_run(30);
    drive(30);
    for (int c = 0; c < 30; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL single_run cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
    checks++;
    if (obs_a[1][10] !== 1'b1) begin
      errors++; $display("FAIL single_init_c1: got %b expected 1", obs_a[1][10]);
    end
    checks++;
    if (obs_a[21][8:4] !== 5'd19 || obs_a[21][9] !== 1'b1 || obs_a[21][2] !== 1'b1) begin
      errors++; $display("FAIL single_last_step_c21: got %h expected idx 19 en 1 freeze 1", obs_a[21]);
    end
    checks++;
    if (obs_a[22][0] !== 1'b1 || obs_a[22][1] !== 1'b1) begin
      errors++; $display("FAIL single_done_c22: got %h expected done 1 wb_ready 1", obs_a[22]);
    end
    checks++;
    if (obs_a[23][3] !== 1'b0) begin
      errors++; $display("FAIL single_busy_c23: got %b expected 0", obs_a[23][3]);
    end
  endtask

  task automatic test_hold();
    logic [10:0] e;
    clear_stim();
    for (int c = 0; c <= 25; c++) start_a[c] = 1'b1;
    for (int c = 7; c <= 9; c++) hold_a[c] = 1'b1;
    model_run(32);
    drive(32);
    for (int c = 0; c < 32; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
    for (int c = 7; c <= 9; c++) begin
      checks++;
      if (obs_a[c][9] !== 1'b0 || obs_a[c][8:4] !== 5'd5 || obs_a[c][2] !== 1'b1) begin
        errors++; $display("FAIL hold_stall cycle %0d: got %h expected en 0 idx 5 freeze 1", c, obs_a[c]);
      end
    end
    checks++;
    if (obs_a[22][0] !== 1'b0 || obs_a[25][0] !== 1'b1) begin
      errors++; $display("FAIL hold_done_shift: got c22=%b c25=%b expected 0 1", obs_a[22][0], obs_a[25][0]);
    end
  endtask

  task automatic test_flush();
    logic [10:0] e;
    int ndone;
    clear_stim();
    for (int c = 0; c <= 12; c++) start_a[c] = 1'b1;
    flush_a[12] = 1'b1;
    model_run(45);
    drive(45);
    for (int c = 0; c < 45; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL flush cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
    checks++;
    if (obs_a[12][9] !== 1'b0 || obs_a[12][2] !== 1'b0 || obs_a[12][8:4] !== 5'd10) begin
      errors++; $display("FAIL flush_cycle: got %h expected en 0 freeze 0 idx 10", obs_a[12]);
    end
    checks++;
    if (obs_a[13][8:4] !== 5'd0 || obs_a[13][3] !== 1'b0) begin
      errors++; $display("FAIL flush_idle_after: got %h expected idx 0 busy 0", obs_a[13]);
    end
    ndone = 0;
    for (int c = 12; c < 45; c++) if (obs_a[c][0] === 1'b1) ndone++;
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL flush_no_done: got %0d done pulses expected 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    clear_stim();
    for (int c = 0; c <= 45; c++) start_a[c] = 1'b1;
    model_run(52);
    drive(52);
    for (int c = 0; c < 52; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL b2b cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
    checks++;
    if (obs_a[22][0] !== 1'b1 || obs_a[45][0] !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got c22=%b c45=%b expected 1 1", obs_a[22][0], obs_a[45][0]);
    end
    checks++;
    if (obs_a[23][2] !== 1'b1 || obs_a[24][10] !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: got freeze23=%b init24=%b expected 1 1", obs_a[23][2], obs_a[24][10]);
    end
  endtask

  task automatic test_random();
    logic [10:0] e;
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      for (int c = 0; c < 80; c++) begin
        start_a[c] = (c < 70) ? ($urandom_range(0, 30) != 0) : 1'b0;
        hold_a[c]  = ($urandom_range(0, 3) == 0);
        flush_a[c] = ($urandom_range(0, 49) == 0);
      end
      model_run(80);
      drive(80);
      for (int c = 0; c < 80; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_a[c] !== e) begin
          errors++;
          $display("FAIL random r%0d cycle %0d: got %h expected %h", r, c, obs_a[c], e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    clear_stim();
    for (int c = 0; c < 9; c++) start_a[c] = 1'b1;
    model_run(9);
    drive(9);
    for (int c = 0; c < 9; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL areset_pre cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
    start = 1'b1; hold = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (iter_idx !== 5'd7 || iter_en !== 1'b1) begin
      errors++; $display("FAIL areset_mid: got idx %0d en %b expected 7 1", iter_idx, iter_en);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (freeze !== 1'b0 || busy !== 1'b0 || iter_en !== 1'b0 || iter_idx !== 5'd0) begin
      errors++; $display("FAIL areset_drop: got freeze %b busy %b en %b idx %0d expected 0 0 0 0",
                         freeze, busy, iter_en, iter_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_stim();
    for (int c = 0; c <= 22; c++) start_a[c] = 1'b1;
    model_run(28);
    drive(28);
    for (int c = 0; c < 28; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_a[c] !== e) begin
        errors++;
        $display("FAIL areset_post cycle %0d: got %h expected %h", c, obs_a[c], e);
      end
    end
    checks++;
    if (obs_a[21][0] !== 1'b0 || obs_a[22][0] !== 1'b1) begin
      errors++; $display("FAIL areset_done_c22: got c21=%b c22=%b expected 0 1", obs_a[21][0], obs_a[22][0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_run();
    test_hold();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_exp_sequencer
